// File: rtl/mlaccel_smem_responder_if.sv
// Signal bundle between the smem responder, its two requesters (sequencer fetch
// port and host/SPI bridge) and the 16-bit smem RAM macro.
interface mlaccel_smem_responder_if #(
    parameter int unsigned ADDR_BITS = 16
);
    // Sequencer 32-bit fetch port
    logic                 seq_valid;
    logic                 seq_ready;
    logic [ADDR_BITS-1:0] seq_addr;
    logic [31:0]          seq_data;

    // Host 16-bit read/write port
    logic                 host_valid;
    logic                 host_ready;
    logic                 host_write;
    logic [ADDR_BITS-1:0] host_addr;
    logic [15:0]          host_wdata;
    logic [15:0]          host_rdata;

    // smem RAM macro port
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_wen;
    logic [15:0]          mem_wdata;
    logic [15:0]          mem_rdata;

    // Responder side
    modport slave (
        input  seq_valid, seq_addr,
        input  host_valid, host_write, host_addr, host_wdata,
        input  mem_rdata,
        output seq_ready, seq_data,
        output host_ready, host_rdata,
        output mem_addr, mem_wen, mem_wdata
    );

    // Requester side plus RAM model
    modport master (
        output seq_valid, seq_addr,
        output host_valid, host_write, host_addr, host_wdata,
        output mem_rdata,
        input  seq_ready, seq_data,
        input  host_ready, host_rdata,
        input  mem_addr, mem_wen, mem_wdata
    );
endinterface

// File: rtl/mlaccel_smem_responder.sv
// smem responder: serves 32-bit sequencer fetches as two consecutive 16-bit RAM
// reads and shares the RAM with a 16-bit host read/write port through a registered
// arbiter FSM. All outputs, including the RAM port, come straight from flops.
module mlaccel_smem_responder #(
    parameter int unsigned ADDR_BITS       = 16,
    parameter bit          ARB_ROUND_ROBIN = 1'b1
) (
    input logic                     clock,
    input logic                     reset,
    mlaccel_smem_responder_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StSLo,
        StSHi,
        StSCap,
        StSDone,
        StHRd,
        StHCap,
        StHDone
    } state_t;

    state_t               state_q;
    logic                 last_seq_q;   // 1: most recent grant went to the sequencer
    logic [ADDR_BITS-1:0] addr_q;       // fetch address latched at grant
    logic [15:0]          lo_q;         // low half of the fetch, waiting for the high half
    logic [ADDR_BITS-1:0] mem_addr_q;
    logic                 mem_wen_q;
    logic [15:0]          mem_wdata_q;
    logic                 seq_ready_q;
    logic [31:0]          seq_data_q;
    logic                 host_ready_q;
    logic [15:0]          host_rdata_q;
    logic                 grant_seq;
    logic                 grant_host;

    // Arbitration: a lone requester wins; on a tie round-robin flips away from the
    // last grant, otherwise the host wins.
    always_comb begin
        grant_seq  = 1'b0;
        grant_host = 1'b0;
        if (bus.seq_valid && bus.host_valid) begin
            if (ARB_ROUND_ROBIN && !last_seq_q) begin
                grant_seq = 1'b1;
            end else begin
                grant_host = 1'b1;
            end
        end else begin
            grant_seq  = bus.seq_valid;
            grant_host = bus.host_valid;
        end
    end

    // Arbiter/sequencing FSM with registered RAM port and response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            last_seq_q   <= 1'b0;
            addr_q       <= '0;
            lo_q         <= '0;
            mem_addr_q   <= '0;
            mem_wen_q    <= 1'b0;
            mem_wdata_q  <= '0;
            seq_ready_q  <= 1'b0;
            seq_data_q   <= '0;
            host_ready_q <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            // Pulses last exactly one cycle unless a state re-asserts them.
            mem_wen_q    <= 1'b0;
            seq_ready_q  <= 1'b0;
            host_ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_seq) begin
                        last_seq_q <= 1'b1;
                        addr_q     <= bus.seq_addr;
                        mem_addr_q <= bus.seq_addr;
                        state_q    <= StSLo;
                    end else if (grant_host) begin
                        last_seq_q <= 1'b0;
                        mem_addr_q <= bus.host_addr;
                        if (bus.host_write) begin
                            // Write completes in the very next cycle alongside its ready.
                            mem_wdata_q  <= bus.host_wdata;
                            mem_wen_q    <= 1'b1;
                            host_ready_q <= 1'b1;
                            state_q      <= StHDone;
                        end else begin
                            state_q <= StHRd;
                        end
                    end
                end
                StSLo: begin
                    mem_addr_q <= addr_q + ADDR_BITS'(1);
                    state_q    <= StSHi;
                end
                StSHi: begin
                    lo_q    <= bus.mem_rdata;
                    state_q <= StSCap;
                end
                StSCap: begin
                    seq_data_q  <= {bus.mem_rdata, lo_q};
                    seq_ready_q <= 1'b1;
                    state_q     <= StSDone;
                end
                StSDone: state_q <= StIdle;
                StHRd:   state_q <= StHCap;
                StHCap: begin
                    host_rdata_q <= bus.mem_rdata;
                    host_ready_q <= 1'b1;
                    state_q      <= StHDone;
                end
                StHDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wen    = mem_wen_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.seq_ready  = seq_ready_q;
    assign bus.seq_data   = seq_data_q;
    assign bus.host_ready = host_ready_q;
    assign bus.host_rdata = host_rdata_q;

endmodule

// File: tb/tb_mlaccel_smem_responder.sv
// Bench for mlaccel_smem_responder: one round-robin instance (a) and one
// host-priority instance (b), each with its own behavioural RAM. Expected data
// comes from a word-level memory model; grant order from a last-grant model.
module tb_mlaccel_smem_responder;

    localparam int unsigned AB      = 16;
    localparam int          TIMEOUT = 40;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mlaccel_smem_responder_if #(.ADDR_BITS(AB)) bus_a ();
    mlaccel_smem_responder_if #(.ADDR_BITS(AB)) bus_b ();

    mlaccel_smem_responder #(.ADDR_BITS(AB), .ARB_ROUND_ROBIN(1'b1)) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (bus_a)
    );

    mlaccel_smem_responder #(.ADDR_BITS(AB), .ARB_ROUND_ROBIN(1'b0)) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (bus_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int seq_pulses_a = 0;
    logic [31:0] mem_seed = 32'h0;
    bit last_host_a = 1'b1;   // model: last grant of instance a went to host

    // Written-word overlay on top of a seeded pseudo-random initial image.
    bit [15:0] ram_a_val [65536];
    bit        ram_a_wr  [65536];
    bit [15:0] ram_b_val [65536];
    bit        ram_b_wr  [65536];
    bit [15:0] ref_val   [65536];
    bit        ref_wr    [65536];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        logic [31:0] h;
        h = {16'h0, a} * 32'h9E3779B1 + mem_seed;
        h = h ^ (h >> 15);
        return h[15:0];
    endfunction

    function automatic logic [15:0] ref_word(input logic [15:0] a);
        return ref_wr[a] ? ref_val[a] : init_val(a);
    endfunction

    // Instance b is never written, so its expected contents stay at the initial image.
    function automatic logic [15:0] exp_word(input int inst, input logic [15:0] a);
        return (inst == 0) ? ref_word(a) : init_val(a);
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) if (bus_a.seq_ready === 1'b1) seq_pulses_a <= seq_pulses_a + 1;

    // Synchronous 16-bit RAMs: read data appears the cycle after the address.
    always @(posedge clock) begin
        bus_a.mem_rdata <= ram_a_wr[bus_a.mem_addr] ? ram_a_val[bus_a.mem_addr]
                                                    : init_val(bus_a.mem_addr);
        if (bus_a.mem_wen) begin
            ram_a_wr[bus_a.mem_addr]  <= 1'b1;
            ram_a_val[bus_a.mem_addr] <= bus_a.mem_wdata;
        end
    end

    always @(posedge clock) begin
        bus_b.mem_rdata <= ram_b_wr[bus_b.mem_addr] ? ram_b_val[bus_b.mem_addr]
                                                    : init_val(bus_b.mem_addr);
        if (bus_b.mem_wen) begin
            ram_b_wr[bus_b.mem_addr]  <= 1'b1;
            ram_b_val[bus_b.mem_addr] <= bus_b.mem_wdata;
        end
    end

    function automatic logic get_seq_ready(input int inst);
        return (inst == 0) ? bus_a.seq_ready : bus_b.seq_ready;
    endfunction
    function automatic logic [31:0] get_seq_data(input int inst);
        return (inst == 0) ? bus_a.seq_data : bus_b.seq_data;
    endfunction
    function automatic logic get_host_ready(input int inst);
        return (inst == 0) ? bus_a.host_ready : bus_b.host_ready;
    endfunction
    function automatic logic [15:0] get_host_rdata(input int inst);
        return (inst == 0) ? bus_a.host_rdata : bus_b.host_rdata;
    endfunction
    function automatic logic get_mem_wen(input int inst);
        return (inst == 0) ? bus_a.mem_wen : bus_b.mem_wen;
    endfunction

    task automatic drive_seq(input int inst, input logic v, input logic [15:0] a);
        if (inst == 0) begin
            bus_a.seq_valid = v;
            bus_a.seq_addr  = a;
        end else begin
            bus_b.seq_valid = v;
            bus_b.seq_addr  = a;
        end
    endtask

    task automatic drive_host(input int inst, input logic v, input logic w,
                              input logic [15:0] a, input logic [15:0] d);
        if (inst == 0) begin
            bus_a.host_valid = v; bus_a.host_write = w;
            bus_a.host_addr  = a; bus_a.host_wdata = d;
        end else begin
            bus_b.host_valid = v; bus_b.host_write = w;
            bus_b.host_addr  = a; bus_b.host_wdata = d;
        end
    endtask

    // Sequencer fetch: raise valid at a negedge, wait for ready, drop valid, then
    // confirm the pulse was single-cycle and the data holds afterwards.
    task automatic seq_req(input int inst, input logic [15:0] addr, input bit scramble,
                           output logic [31:0] data, output int lat, output int done_cyc);
        bit got;
        got = 1'b0; lat = 0; data = '0; done_cyc = 0;
        drive_seq(inst, 1'b1, addr);
        for (int i = 1; i <= TIMEOUT && !got; i++) begin
            @(negedge clock);
            if (get_seq_ready(inst) === 1'b1) begin
                got = 1'b1; lat = i; data = get_seq_data(inst); done_cyc = cyc;
            end else if (scramble) begin
                drive_seq(inst, 1'b1, 16'($urandom));
            end
        end
        drive_seq(inst, 1'b0, 16'($urandom));
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL seq_timeout inst=%0d addr=%h: no seq_ready within %0d cycles",
                     inst, addr, TIMEOUT);
        end else begin
            if (inst == 0) last_host_a = 1'b0;
            @(negedge clock);
            if (get_seq_ready(inst) !== 1'b0 || get_seq_data(inst) !== data) begin
                errors++;
                $display("FAIL seq_pulse inst=%0d: ready=%b data=%h, required ready=0 data=%h",
                         inst, get_seq_ready(inst), get_seq_data(inst), data);
            end
        end
    endtask

    // Host access, same handshake; completed writes update the model.
    task automatic host_req(input int inst, input logic w, input logic [15:0] addr,
                            input logic [15:0] wdata, output logic [15:0] rdata,
                            output int lat, output int done_cyc);
        bit got;
        got = 1'b0; lat = 0; rdata = '0; done_cyc = 0;
        drive_host(inst, 1'b1, w, addr, wdata);
        for (int i = 1; i <= TIMEOUT && !got; i++) begin
            @(negedge clock);
            if (get_host_ready(inst) === 1'b1) begin
                got = 1'b1; lat = i; rdata = get_host_rdata(inst); done_cyc = cyc;
            end
        end
        drive_host(inst, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL host_timeout inst=%0d addr=%h: no host_ready within %0d cycles",
                     inst, addr, TIMEOUT);
        end else begin
            if (get_mem_wen(inst) !== w) begin
                errors++;
                $display("FAIL host_wen inst=%0d: mem_wen=%b during ready, required %b",
                         inst, get_mem_wen(inst), w);
            end
            if (inst == 0) begin
                last_host_a = 1'b1;
                if (w) begin
                    ref_wr[addr]  = 1'b1;
                    ref_val[addr] = wdata;
                end
            end
            @(negedge clock);
            checks++;
            if (get_host_ready(inst) !== 1'b0 || get_mem_wen(inst) !== 1'b0 ||
                (!w && get_host_rdata(inst) !== rdata)) begin
                errors++;
                $display("FAIL host_pulse inst=%0d: ready=%b wen=%b rdata=%h, required 0 0 %h",
                         inst, get_host_ready(inst), get_mem_wen(inst),
                         get_host_rdata(inst), rdata);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({bus_a.seq_ready, bus_a.host_ready, bus_a.mem_wen} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: seq_ready/host_ready/mem_wen=%b, required 000",
                     {bus_a.seq_ready, bus_a.host_ready, bus_a.mem_wen});
        end
        checks++;
        if (bus_a.seq_data !== 32'h0 || bus_a.host_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: seq_data=%h host_rdata=%h, required 0 0",
                     bus_a.seq_data, bus_a.host_rdata);
        end
        checks++;
        if (bus_a.mem_addr !== 16'h0 || bus_a.mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_mem: mem_addr=%h mem_wdata=%h, required 0 0",
                     bus_a.mem_addr, bus_a.mem_wdata);
        end
        checks++;
        if ({bus_b.seq_ready, bus_b.host_ready, bus_b.mem_wen} !== 3'b000) begin
            errors++;
            $display("FAIL reset_b: flags=%b, required 000",
                     {bus_b.seq_ready, bus_b.host_ready, bus_b.mem_wen});
        end
        reset = 1'b0;
        last_host_a = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_write_fetch();
        logic [15:0] rd; logic [31:0] d; int lat; int dc;
        host_req(0, 1'b1, 16'h0010, 16'h1234, rd, lat, dc);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL write_latency: %0d cycles, required 1", lat);
        end
        host_req(0, 1'b1, 16'h0011, 16'hABCD, rd, lat, dc);
        seq_req(0, 16'h0010, 1'b0, d, lat, dc);
        checks++;
        if (d !== 32'hABCD1234) begin
            errors++; $display("FAIL fetch_data: seq_data=%h, required ABCD1234", d);
        end
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL fetch_latency: %0d cycles, required 4", lat);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] rd; logic [31:0] d; int lat; int dc;
        host_req(0, 1'b1, 16'hFFFF, 16'h5555, rd, lat, dc);
        host_req(0, 1'b1, 16'h0000, 16'h6666, rd, lat, dc);
        seq_req(0, 16'hFFFF, 1'b0, d, lat, dc);
        checks++;
        if (d !== 32'h66665555) begin
            errors++; $display("FAIL wrap_data: seq_data=%h, required 66665555", d);
        end
    endtask

    task automatic test_host_read();
        logic [15:0] rd; logic [15:0] a; int lat; int dc; int p0;
        host_req(0, 1'b1, 16'h0042, 16'hBEEF, rd, lat, dc);
        p0 = seq_pulses_a;
        host_req(0, 1'b0, 16'h0042, 16'h0000, rd, lat, dc);
        checks++;
        if (rd !== 16'hBEEF || lat !== 3) begin
            errors++;
            $display("FAIL host_read: rdata=%h latency=%0d, required BEEF 3", rd, lat);
        end
        for (int i = 0; i < 4; i++) begin
            a = (i < 2) ? 16'h0010 + 16'(i) : 16'($urandom);
            host_req(0, 1'b0, a, 16'h0000, rd, lat, dc);
            checks++;
            if (rd !== ref_word(a)) begin
                errors++;
                $display("FAIL host_read_rand addr=%h: rdata=%h, required %h", a, rd, ref_word(a));
            end
        end
        checks++;
        if (seq_pulses_a !== p0) begin
            errors++;
            $display("FAIL host_read_seq_ready: %0d seq_ready pulses, required 0", seq_pulses_a - p0);
        end
    endtask

    // Both requesters raise valid in the same cycle with the FSM idle.
    task automatic arb_round(input int inst);
        logic [15:0] ha; logic [15:0] sa; logic [15:0] sa1;
        logic [15:0] hexp; logic [31:0] sexp;
        logic [15:0] hdata; logic [31:0] sdata;
        int hl; int sl; int hd; int sd;
        bit exp_host_first;
        ha = 16'($urandom); sa = 16'($urandom); sa1 = sa + 16'd1;
        hexp = exp_word(inst, ha);
        sexp = {exp_word(inst, sa1), exp_word(inst, sa)};
        exp_host_first = (inst == 0) ? !last_host_a : 1'b1;
        fork
            seq_req(inst, sa, 1'b0, sdata, sl, sd);
            host_req(inst, 1'b0, ha, 16'h0000, hdata, hl, hd);
        join
        checks++;
        if ((hd < sd) !== exp_host_first) begin
            errors++;
            $display("FAIL arb_order inst=%0d: host_first=%b, required %b",
                     inst, (hd < sd), exp_host_first);
        end
        checks++;
        if (sdata !== sexp || hdata !== hexp) begin
            errors++;
            $display("FAIL arb_data inst=%0d: seq=%h host=%h, required %h %h",
                     inst, sdata, hdata, sexp, hexp);
        end
        checks++;
        if ((exp_host_first && hl !== 3) || (!exp_host_first && sl !== 4)) begin
            errors++;
            $display("FAIL arb_latency inst=%0d: host=%0d seq=%0d, required winner 3 (host) or 4 (seq)",
                     inst, hl, sl);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] d; logic [15:0] rd; int lat; int dc;
        for (int inst = 0; inst < 2; inst++) begin
            seq_req(inst, 16'($urandom), 1'b0, d, lat, dc);
            for (int r = 0; r < 4; r++) arb_round(inst);
            host_req(inst, 1'b0, 16'($urandom), 16'h0000, rd, lat, dc);
            arb_round(inst);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [15:0] a; logic [15:0] a1; int lat; int dc; int p0;
        a = 16'h0010; a1 = a + 16'd1;
        drive_seq(0, 1'b1, a);
        repeat (2) @(negedge clock);
        p0 = seq_pulses_a;
        reset = 1'b1;
        drive_seq(0, 1'b0, a);
        @(negedge clock);
        reset = 1'b0;
        last_host_a = 1'b1;
        checks++;
        if (bus_a.mem_wen !== 1'b0 || bus_a.seq_ready !== 1'b0 || bus_a.seq_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: wen=%b ready=%b data=%h, required 0 0 0",
                     bus_a.mem_wen, bus_a.seq_ready, bus_a.seq_data);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (seq_pulses_a !== p0) begin
            errors++;
            $display("FAIL reset_mid_ready: %0d seq_ready pulses after abort, required 0",
                     seq_pulses_a - p0);
        end
        seq_req(0, a, 1'b0, d, lat, dc);
        checks++;
        if (d !== {ref_word(a1), ref_word(a)} || lat !== 4) begin
            errors++;
            $display("FAIL reset_refetch: data=%h latency=%0d, required %h 4",
                     d, lat, {ref_word(a1), ref_word(a)});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd; logic [15:0] a; logic [15:0] a1; logic [31:0] d; logic [31:0] e;
        int lat; int dc; int p0;
        for (int i = 0; i < 16; i++) begin
            host_req(0, 1'b1, 16'h0100 + 16'($urandom_range(0, 15)), 16'($urandom), rd, lat, dc);
        end
        p0 = seq_pulses_a;
        for (int i = 0; i < 32; i++) begin
            a  = ($urandom_range(0, 1) == 1) ? 16'h00FF + 16'($urandom_range(0, 16))
                                             : 16'($urandom);
            a1 = a + 16'd1;
            e  = {ref_word(a1), ref_word(a)};
            seq_req(0, a, 1'b1, d, lat, dc);
            checks++;
            if (d !== e || lat !== 4) begin
                errors++;
                $display("FAIL stream[%0d] addr=%h: data=%h latency=%0d, required %h 4",
                         i, a, d, lat, e);
            end
        end
        checks++;
        if (seq_pulses_a - p0 !== 32) begin
            errors++;
            $display("FAIL stream_pulses: %0d seq_ready pulses, required 32", seq_pulses_a - p0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem_seed = $urandom;
        reset = 1'b1;
        drive_seq(0, 1'b0, 16'h0);
        drive_seq(1, 1'b0, 16'h0);
        drive_host(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_host(1, 1'b0, 1'b0, 16'h0, 16'h0);
        test_reset();
        test_write_fetch();
        test_wrap();
        test_host_read();
        test_arbitration();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
